cap_sense_scanner: RTL
======================

# cap_sense_scanner

Capacitive touch front-end for the nine mole pads of the whack-a-mole board. It is the input-side counterpart of the processor's LED output path. It drives the shared charge line `capacitive_sensors_out`, measures each pad's rise time on `capacitive_sensors_in`, and debounces the result into per-pad touch levels. Sticky touch events are held for the processor to read and clear. It sits beside the processor in `skeleton`, between the board pins and the processor's memory-mapped input space.

## Interface
- `N_SENSORS`, 9: number of pads.
- `CHARGE_MAX`, 1023: charge-phase timeout in cycles; counter width is `$clog2(CHARGE_MAX+1)`.
- `THRESHOLD`, 200: rise-time count at or above which a pad reads as touched.
- `DISCHARGE_CYCLES`, 64: length of each discharge phase.
- `DEBOUNCE_SCANS`, 2: consecutive agreeing scans required to change a `touched` bit.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `capacitive_sensors_in` in N_SENSORS: raw pad inputs, asynchronous.
- `capacitive_sensors_out` out 1: charge line; 0 = discharge, 1 = charge.
- `clear_event` in N_SENSORS: write-1-to-clear mask for `touch_event`, one-cycle pulse from the processor.
- `touched` out N_SENSORS: debounced touch level per pad.
- `touch_event` out N_SENSORS: sticky flag, set on a `touched` 0→1 transition.
- `scan_done` out 1: one-cycle pulse marking the cycle `touched` updates.

## Operation
- Each input passes through a 2-flop synchronizer; all decisions use the synchronized value.
- FSM states: DISCHARGE, CHARGE, EVALUATE.
- Reset enters DISCHARGE with its cycle counter at 0.
- DISCHARGE:
  - `capacitive_sensors_out`=0 for exactly DISCHARGE_CYCLES cycles, then → CHARGE.
- CHARGE:
  - `capacitive_sensors_out`=1; counter starts at 0 on the first CHARGE cycle and increments by 1 per cycle.
  - A pad's rise time is captured in the first cycle its synchronized input is 1, using that cycle's counter value. It is captured once per scan and never overwritten.
  - A pad already high on the first CHARGE cycle captures 0, meaning not touched.
  - Leave CHARGE → EVALUATE when all pads are captured or the counter equals CHARGE_MAX, whichever comes first.
  - At timeout, every uncaptured pad is assigned CHARGE_MAX and therefore reads as touched.
- EVALUATE (1 cycle):
  - raw[i] = (time[i] >= THRESHOLD).
  - Per pad, a debounce counter increments when raw[i] != touched[i]; it is cleared to 0 when they are equal.
  - When the counter reaches DEBOUNCE_SCANS, touched[i] ← raw[i] and the counter clears.
  - Next state is DISCHARGE.
- touch_event[i]:
  - Set when touched[i] goes 0→1.
  - Cleared by clear_event[i]=1.
  - If set and clear happen in the same cycle, set wins.
  - Clearing an already-clear bit has no effect.

## Timing
- Reset values: `capacitive_sensors_out`=0, `touched`=0, `touch_event`=0, `scan_done`=0. All capture registers and debounce counters are 0.
- Reset asserted in any state: outputs take their reset values on the next edge, and the scan restarts from DISCHARGE cycle 0. The partial scan is discarded.
- Latency:
  - A pin edge appears in the capture logic 2 cycles after it is sampled.
  - Captured counts therefore include this 2-cycle offset; THRESHOLD is specified against the captured count.
- `touched` and `scan_done` register at the EVALUATE clock edge. Both are visible in the first DISCHARGE cycle of the next scan.
- `touch_event` sets in the same cycle `touched` rises.
- Scan period is DISCHARGE_CYCLES + (charge cycles) + 1. The maximum is 64 + 1024 + 1 = 1089 with defaults.
- `clear_event` takes effect on the next edge and is accepted in any FSM state.

## Structure
- Package `cap_sense_pkg` holds:
  - the state enum (DISCHARGE, CHARGE, EVALUATE);
  - default values of the five parameters;
  - a `cnt_w` function returning `$clog2(CHARGE_MAX+1)`.
- Sub-module `cap_sense_channel` is instantiated N_SENSORS times. It contains one pad's synchronizer, captured-flag, rise-time register, debounce counter, touched bit and touch_event bit.
  - The top level owns the FSM, the shared charge counter and the global done detection (AND of captured flags).

## Test plan
- **Reset and phasing:** hold `reset` 3 cycles, then release → all outputs 0; `capacitive_sensors_out` stays 0 for 64 cycles, then 1.
- **Untouched pads:** all inputs rise 10 cycles into CHARGE → CHARGE ends about 12 cycles in; `scan_done` pulses once per scan; `touched`=9'h000 after 5 scans.
- **Single touch:** pad 4 rises 300 cycles into CHARGE, others at 10 →
  - after scan 1: `touched`=0;
  - after scan 2: `touched`=9'h010 and `touch_event`=9'h010;
  - a one-scan-only slow rise on pad 4 never sets `touched`.
- **Timeout:** pad 8 held 0 → CHARGE lasts 1024 cycles; after 2 scans `touched[8]`=1.
- **Event clear race:**
  - `clear_event`=9'h010 in the same cycle `touched[4]` rises → `touch_event[4]` stays 1;
  - a later lone `clear_event`=9'h010 → 0.
- **Reset mid-CHARGE:** assert `reset` at charge cycle 150 → next cycle `capacitive_sensors_out`=0, `touched`=0, `touch_event`=0; the following scan runs a full 64-cycle DISCHARGE.

Source files
------------

// File: rtl/cap_sense_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cap_sense_pkg
// Brief    : Shared state encoding, default parameters and width helper for
//            the capacitive touch scanner.
// Revision : 1.0 - initial release
// ============================================================================
package cap_sense_pkg;

    typedef enum logic [1:0] {
        DISCHARGE = 2'd0,
        CHARGE    = 2'd1,
        EVALUATE  = 2'd2
    } state_t;

    localparam int c_N_SENSORS        = 9;
    localparam int c_CHARGE_MAX       = 1023;
    localparam int c_THRESHOLD        = 200;
    localparam int c_DISCHARGE_CYCLES = 64;
    localparam int c_DEBOUNCE_SCANS   = 2;

    function automatic int cnt_w(input int charge_max);
        return $clog2(charge_max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cap_sense_channel.sv
`default_nettype none
// ============================================================================
// Module   : cap_sense_channel
// Brief    : One pad: input synchronizer, rise-time capture, debounce and
//            sticky touch event.
// Revision : 1.0 - initial release
// ============================================================================
module cap_sense_channel #(
    parameter int CNT_W          = 10,
    parameter int THRESHOLD      = 200,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pad,
    input  logic             i_discharge,
    input  logic             i_charge,
    input  logic             i_timeout,
    input  logic             i_evaluate,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_clear_event,
    output logic             o_captured,
    output logic             o_touched,
    output logic             o_touch_event
);

    localparam int               c_DBW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] c_THRESHOLD = CNT_W'(THRESHOLD);
    localparam logic [c_DBW-1:0] c_DEBOUNCE  = c_DBW'(DEBOUNCE_SCANS);

    logic [1:0]       r_sync;
    logic             r_captured;
    logic [CNT_W-1:0] r_time;
    logic [c_DBW-1:0] r_dbnc;
    logic             r_touched;
    logic             r_event;

    logic             w_raw;
    logic             w_differ;
    logic [c_DBW-1:0] w_dbnc_inc;
    logic             w_commit;
    logic             w_rise;

    always_comb begin
        w_raw      = (r_time >= c_THRESHOLD);
        w_differ   = (w_raw != r_touched);
        w_dbnc_inc = r_dbnc + c_DBW'(1);
        w_commit   = i_evaluate && w_differ && (w_dbnc_inc == c_DEBOUNCE);
        w_rise     = w_commit && w_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_captured <= 1'b0;
            r_time     <= '0;
            r_dbnc     <= '0;
            r_touched  <= 1'b0;
            r_event    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pad};
            // A timed-out pad latches the counter, which then equals CHARGE_MAX
            if (i_discharge) begin
                r_captured <= 1'b0;
                r_time     <= '0;
            end else if (i_charge && !r_captured && (r_sync[1] || i_timeout)) begin
                r_captured <= 1'b1;
                r_time     <= i_count;
            end
            if (i_evaluate) begin
                if (!w_differ || w_commit) begin
                    r_dbnc <= '0;
                end else begin
                    r_dbnc <= w_dbnc_inc;
                end
            end
            if (w_commit) begin
                r_touched <= w_raw;
            end
            r_event <= (r_event & ~i_clear_event) | w_rise;
        end
    end

    assign o_captured    = r_captured;
    assign o_touched     = r_touched;
    assign o_touch_event = r_event;

endmodule
`default_nettype wire

// File: rtl/cap_sense_scanner.sv
`default_nettype none
// ============================================================================
// Module   : cap_sense_scanner
// Brief    : Discharge/charge/evaluate scan sequencer over N capacitive pads.
// Revision : 1.0 - initial release
// ============================================================================
module cap_sense_scanner
    import cap_sense_pkg::*;
#(
    parameter int N_SENSORS        = c_N_SENSORS,
    parameter int CHARGE_MAX       = c_CHARGE_MAX,
    parameter int THRESHOLD        = c_THRESHOLD,
    parameter int DISCHARGE_CYCLES = c_DISCHARGE_CYCLES,
    parameter int DEBOUNCE_SCANS   = c_DEBOUNCE_SCANS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] capacitive_sensors_in,
    output logic                 capacitive_sensors_out,
    input  logic [N_SENSORS-1:0] clear_event,
    output logic [N_SENSORS-1:0] touched,
    output logic [N_SENSORS-1:0] touch_event,
    output logic                 scan_done
);

    localparam int c_TW = cnt_w(CHARGE_MAX);
    localparam int c_DW = $clog2(DISCHARGE_CYCLES);
    localparam int c_CW = (c_TW > c_DW) ? c_TW : c_DW;
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(CHARGE_MAX);
    localparam logic [c_CW-1:0] c_DIS_LAST = c_CW'(DISCHARGE_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CW-1:0]     r_cnt;
    logic                r_scan_done;
    logic [N_SENSORS-1:0] w_captured;
    logic                w_all_captured;
    logic                w_discharging;
    logic                w_charging;
    logic                w_evaluate;
    logic                w_timeout;

    // The shared counter restarts at 0 on every state change
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= DISCHARGE;
            r_cnt       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= (w_next_state != r_state) ? '0 : r_cnt + c_CW'(1);
            r_scan_done <= (r_state == EVALUATE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DISCHARGE: if (r_cnt == c_DIS_LAST)          w_next_state = CHARGE;
            CHARGE:    if (w_all_captured || w_timeout) w_next_state = EVALUATE;
            EVALUATE:                                   w_next_state = DISCHARGE;
            default:                                    w_next_state = DISCHARGE;
        endcase
    end

    always_comb begin
        w_discharging = (r_state == DISCHARGE);
        w_charging    = (r_state == CHARGE);
        w_evaluate    = (r_state == EVALUATE);
        w_timeout     = w_charging && (r_cnt == c_CNT_MAX);
    end

    assign w_all_captured         = &w_captured;
    assign capacitive_sensors_out = w_charging;
    assign scan_done              = r_scan_done;

    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_channel
        cap_sense_channel #(
            .CNT_W          (c_TW),
            .THRESHOLD      (THRESHOLD),
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
        ) u_channel (
            .clk           (clock),
            .rst           (reset),
            .i_pad         (capacitive_sensors_in[gi]),
            .i_discharge   (w_discharging),
            .i_charge      (w_charging),
            .i_timeout     (w_timeout),
            .i_evaluate    (w_evaluate),
            .i_count       (r_cnt[c_TW-1:0]),
            .i_clear_event (clear_event[gi]),
            .o_captured    (w_captured[gi]),
            .o_touched     (touched[gi]),
            .o_touch_event (touch_event[gi])
        );
    end

endmodule
`default_nettype wire
